// File: rtl/infer_seq_pkg.sv
// Shared types and default sizes for the inference sequencer.
package infer_seq_pkg;

  localparam int DEF_ARRAY_DIM = 8;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ROW_W     = DEF_ARRAY_DIM * DEF_DATA_W;

  // Beat and result counters stop at their targets, so 7 bits never wrap.
  localparam int CNT_W = 7;

  typedef logic [DEF_ROW_W-1:0] row_t;

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    STREAM,
    FLUSH,
    DONE
  } infer_seq_state_t;

endpackage

// File: rtl/infer_seq_watchdog.sv
// Idle-result watchdog: counts cycles since the last kick while armed and
// flags the cycle that completes TIMEOUT_CYCLES quiet cycles.
module infer_seq_watchdog
  import infer_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic arm,
  input  logic kick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] idle_cnt;

  // Quiet-cycle counter; restarts whenever disarmed or kicked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (!arm || kick) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + CW'(1);
    end
  end

  // The first armed cycle sees a count of 0, so the final quiet cycle sees
  // TIMEOUT_CYCLES-1; flagging it makes the owner leave exactly on time.
  assign expired = arm && !kick && (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/inference_sequencer.sv
// Command front-end for the systolic array: loads weight rows, streams input
// rows, counts result beats and pulses done.
// Optional build macro INFER_SEQ_TIMEOUT_EN adds an idle-result watchdog that
// ends FLUSH with err=1 after TIMEOUT_CYCLES cycles without a result.
module inference_sequencer
  import infer_seq_pkg::*;
#(
  parameter  int ARRAY_DIM      = DEF_ARRAY_DIM,
  parameter  int DATA_W         = DEF_DATA_W,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int ROW_W          = ARRAY_DIM * DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load_weights,
  input  logic [CNT_W-1:0] cmd_num_inputs,
  input  logic [1:0]       cmd_act_mode,
  input  logic [ROW_W-1:0] cmd_bias,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [ROW_W-1:0] src_data,
  output logic             start_weights,
  output logic             enable,
  output logic [ROW_W-1:0] systolic_data,
  output logic [ROW_W-1:0] bias_vec,
  output logic [1:0]       activation_mode,
  input  logic             activation_ready,
  output logic             busy,
  output logic             done,
  output logic             err
);

  infer_seq_state_t state, state_nx;

  logic [CNT_W-1:0] num_inputs;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] res_cnt;
  logic [CNT_W-1:0] res_next;
  logic             cmd_take;
  logic             accept;
  logic             res_inc;
  logic             last_wbeat;
  logic             last_ibeat;
  logic             expired;

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign src_ready  = (state == WLOAD) || (state == STREAM);
  assign cmd_take   = cmd_valid && cmd_ready;
  assign accept     = src_valid && src_ready;
  assign last_wbeat = (beat_cnt == CNT_W'(ARRAY_DIM - 1));
  assign last_ibeat = (beat_cnt == num_inputs - CNT_W'(1));

  // Results only count while inputs are in flight, and never past the target.
  assign res_inc  = activation_ready && ((state == STREAM) || (state == FLUSH))
                    && (res_cnt != num_inputs);
  assign res_next = res_cnt + CNT_W'(res_inc);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; FLUSH looks at the incoming result so done follows the
  // final result by one cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_load_weights)             state_nx = WLOAD;
          else if (cmd_num_inputs != '0)    state_nx = STREAM;
          else                              state_nx = DONE;
        end
      end
      WLOAD: begin
        if (accept && last_wbeat) state_nx = (num_inputs != '0) ? STREAM : DONE;
      end
      STREAM: begin
        if (accept && last_ibeat) state_nx = FLUSH;
      end
      FLUSH: begin
        if ((res_next == num_inputs) || expired) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Command latch and beat/result counters; the beat counter restarts at the
  // weight-to-input boundary so it indexes input rows directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_inputs <= '0;
      beat_cnt   <= '0;
      res_cnt    <= '0;
    end else if (cmd_take) begin
      num_inputs <= cmd_num_inputs;
      beat_cnt   <= '0;
      res_cnt    <= '0;
    end else begin
      if (accept) beat_cnt <= ((state == WLOAD) && last_wbeat) ? '0 : beat_cnt + CNT_W'(1);
      res_cnt <= res_next;
    end
  end

  // Per-command bias and activation mode, held until the next command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bias_vec        <= '0;
      activation_mode <= '0;
    end else if (cmd_take) begin
      bias_vec        <= cmd_bias;
      activation_mode <= cmd_act_mode;
    end
  end

  // Array drive stage: one-cycle registered copy of each accepted beat; the
  // data holds through source gaps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable        <= 1'b0;
      start_weights <= 1'b0;
      systolic_data <= '0;
    end else begin
      enable        <= accept;
      start_weights <= accept && (state == WLOAD) && (beat_cnt == '0);
      if (accept) systolic_data <= src_data;
    end
  end

`ifdef INFER_SEQ_TIMEOUT_EN
  logic wd_arm;
  logic err_flag;

  assign wd_arm = (state == FLUSH);

  infer_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .arm    (wd_arm),
    .kick   (activation_ready),
    .expired(expired)
  );

  // Remember that FLUSH ended by timeout rather than by result count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_flag <= 1'b0;
    end else if (cmd_take) begin
      err_flag <= 1'b0;
    end else if ((state == FLUSH) && expired && (res_next != num_inputs)) begin
      err_flag <= 1'b1;
    end
  end

  assign err = done && err_flag;
`else
  assign expired = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: doc/inference_sequencer.md
# inference_sequencer

Control front-end for `fullInference`. Accepts one inference command, then pulls weight rows and input rows from an upstream row buffer over a valid/ready stream. It drives the array's `start_weights`, `enable`, `systolic_data`, `bias_vec` and `activation_mode` pins, counts `activation_ready` result beats, and reports completion. It replaces the hand-sequenced stimulus used to exercise the array today.

## Interface
Parameters:
- `ARRAY_DIM`, 8: rows/columns of the array; weight load is `ARRAY_DIM` beats.
- `DATA_W`, 8: element width; row width `ROW_W = ARRAY_DIM*DATA_W` (64).
- `TIMEOUT_CYCLES`, 255: idle-result watchdog limit; used only with `INFER_SEQ_TIMEOUT_EN`.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when both high; equals (state==IDLE).
- `cmd_load_weights`  in  1  1: load `ARRAY_DIM` weight rows before inputs; 0: reuse resident weights.
- `cmd_num_inputs`  in  7  input rows to stream, 0..127.
- `cmd_act_mode`  in  2  activation mode for this inference.
- `cmd_bias`  in  ROW_W  bias vector for this inference.
- `src_valid`  in  1  upstream row valid.
- `src_ready`  out  1  sequencer takes a row this cycle.
- `src_data`  in  ROW_W  upstream row; weight rows first, then input rows.
- `start_weights`  out  1  one-cycle pulse with the first weight beat.
- `enable`  out  1  `systolic_data` carries a valid row this cycle.
- `systolic_data`  out  ROW_W  row to array.
- `bias_vec`  out  ROW_W  latched bias.
- `activation_mode`  out  2  latched mode.
- `activation_ready`  in  1  array emits one result row.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`: watchdog expired.

## Operation
- States are IDLE, WLOAD, STREAM, FLUSH and DONE.
- **IDLE**
  - On `cmd_valid`, latch `cmd_*`; `bias_vec`/`activation_mode` update next cycle and hold until the next command.
  - Clear the beat and result counters.
  - Go to WLOAD if `cmd_load_weights`; else go to STREAM if `num_inputs` > 0; else go to DONE.
- **WLOAD**
  - `src_ready`=1 until `ARRAY_DIM` beats are accepted.
  - After the last beat, go to STREAM, or to DONE if `num_inputs`==0.
- **STREAM**
  - `src_ready`=1 until `num_inputs` beats are accepted, then go to FLUSH.
- **FLUSH**
  - `src_ready`=0.
  - Stay until result count == `num_inputs`, then go to DONE.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.
- Result counting: `activation_ready` is counted in STREAM and FLUSH. It saturates at `num_inputs`; extra beats and beats in IDLE/WLOAD/DONE are ignored.
- Source gaps: a cycle without an accepted beat gives `enable`=0 next cycle; `systolic_data` holds its last value.
- Counters are 7-bit; no wrap is possible, because the count stops at the target.

## Timing
- Reset values:
  - `start_weights`, `enable`, `systolic_data`, `bias_vec`, `activation_mode`, `done`, `err`, `busy` = 0.
  - `src_ready` = 0.
  - `cmd_ready` = 1, because the FSM is in IDLE.
- Reset mid-operation returns the FSM to IDLE immediately, drops the in-flight command, and drives all outputs to their reset values.
- Command accepted at edge t: state leaves IDLE at t+1, and `src_ready` can be 1 in cycle t+1.
- Beat accepted at edge t (`src_valid`&`src_ready`): `enable`=1 and `systolic_data`=that row in cycle t+1. This is one-cycle registered latency.
- `start_weights`=1 in the same cycle as `enable` for weight beat 0 only.
- `done` is asserted the cycle after the final result is counted; `busy` falls with `done`.
- Back-to-back commands: `cmd_ready` rises the cycle after `done`.

## Configuration
- `INFER_SEQ_TIMEOUT_EN` defined:
  - In FLUSH, a counter counts cycles since the last `activation_ready` and resets on each one.
  - When it reaches `TIMEOUT_CYCLES`, go to DONE with `err`=1 alongside `done`.
- Not defined: FLUSH waits indefinitely, and `err` is tied to 0.

## Structure
- Package `infer_seq_pkg` holds:
  - the state enum `infer_seq_state_t`;
  - `ARRAY_DIM`, `DATA_W`, `ROW_W` defaults;
  - a `row_t` typedef.
- One sub-module, `infer_seq_watchdog`:
  - instantiated only under `INFER_SEQ_TIMEOUT_EN`;
  - inputs `clk`, `rst`, `arm`, `kick`; output `expired`.

## Test plan
- Reset mid-STREAM:
  - Stimulus: assert `rst` after 3 input beats.
  - Response: outputs go to reset values immediately, `cmd_ready`=1, and a new command completes normally.
- Full run with weight load:
  - Stimulus: `load_weights`=1, `num_inputs`=3, `act_mode`=2, bias 0xb0b0b0b0b0b0b0b0, weight rows 0x0202…02, inputs 0x0102030405060708 / 0x050a050a050a050a / 0x0408040804080408, 3 result pulses.
  - Response: `start_weights` is a single pulse, `enable` is high for 11 cycles, `done` pulses with `err`=0.
- Source gap:
  - Stimulus: drop `src_valid` for 1 cycle mid-WLOAD.
  - Response: `enable`=0 for exactly 1 cycle, `systolic_data` unchanged, 8 weight beats total.
- Weight reuse and zero inputs:
  - Stimulus: `load_weights`=0 with `num_inputs`=2; then `load_weights`=1 with `num_inputs`=0.
  - Response: no `start_weights` on the first command; the second command finishes right after 8 weight beats.
- Spurious results:
  - Stimulus: `activation_ready` pulses in IDLE and 2 extra in FLUSH.
  - Response: ignored; `done` fires after exactly `num_inputs` counted.
- Watchdog expiry:
  - Stimulus: with `INFER_SEQ_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=16, withhold results.
  - Response: `done`=`err`=1, 16 cycles after FLUSH entry.
